// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared defaults and helpers for the shared memory arbiter
package mem_arb_pkg;

  localparam int          NPORTS_DEF     = 2;
  localparam int          DEPTH_LOG2_DEF = 10;
  localparam int          NBYTES_DEF     = 4;
  localparam int          ADDR_W         = 17;
  localparam logic [16:0] MBOX_BASE_DEF  = 17'h20;

  // Never returns less than 1 so a width derived from it is always legal.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin grant selection over masked requests
module rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NPORTS = NPORTS_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NPORTS-1:0] req,
  input  logic [NPORTS-1:0] mask,
  output logic [NPORTS-1:0] gnt
);

  localparam int PW = clog2(NPORTS);

  logic [PW-1:0]     ptr_q, ptr_d;
  logic [NPORTS-1:0] req_m;
  logic              found;
  int                idx;

  assign req_m = req & mask;

  // ptr_q names the port searched first; it only moves when a grant is issued.
  always_comb begin
    gnt   = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    idx   = 0;
    for (int off = 0; off < NPORTS; off++) begin
      idx = int'(ptr_q) + off;
      if (idx >= NPORTS) idx = idx - NPORTS;
      if (!found && req_m[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        ptr_d    = (idx == NPORTS - 1) ? '0 : PW'(idx + 1);
      end
    end
    if (!reset) begin
      gnt   = '0;
      ptr_d = '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/shared_memory_arbiter.sv
// rtl/shared_memory_arbiter.sv - multi-port round-robin access to one shared memory
// Optional OWNER_MAILBOX_EN restricts grants to the current mailbox owner.
module shared_memory_arbiter
  import mem_arb_pkg::*;
#(
  parameter int          NPORTS     = NPORTS_DEF,
  parameter int          DEPTH_LOG2 = DEPTH_LOG2_DEF,
  parameter int          NBYTES     = NBYTES_DEF,
  parameter logic [16:0] MBOX_BASE  = MBOX_BASE_DEF
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NPORTS-1:0]            req,
  input  logic [NPORTS*ADDR_W-1:0]     addr,
  input  logic [NPORTS*NBYTES-1:0]     wr_en,
  input  logic [NPORTS*8*NBYTES-1:0]   wdata,
  output logic [NPORTS-1:0]            gnt,
  output logic [8*NBYTES-1:0]          rdata,
  output logic [NPORTS-1:0]            rvalid,
  output logic [clog2(NPORTS)-1:0]     owner
);

  localparam int DW    = 8 * NBYTES;
  localparam int OW    = clog2(NPORTS);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [DW-1:0]         mem_q [0:DEPTH-1];
  logic [DW-1:0]         rdata_q;
  logic [NPORTS-1:0]     rvalid_q;
  logic [NPORTS-1:0]     mask;
  logic                  any_gnt;
  logic [ADDR_W-1:0]     sel_addr;
  logic [NBYTES-1:0]     sel_we;
  logic [DW-1:0]         sel_wdata;
  logic [DEPTH_LOG2-1:0] mem_idx;

  rr_arbiter #(
    .NPORTS (NPORTS)
  ) u_rr_arbiter (
    .clock (clock),
    .reset (reset),
    .req   (req),
    .mask  (mask),
    .gnt   (gnt)
  );

  always_comb begin
    sel_addr  = '0;
    sel_we    = '0;
    sel_wdata = '0;
    for (int p = 0; p < NPORTS; p++) begin
      if (gnt[p]) begin
        sel_addr  = addr[p*ADDR_W +: ADDR_W];
        sel_we    = wr_en[p*NBYTES +: NBYTES];
        sel_wdata = wdata[p*DW +: DW];
      end
    end
  end

  assign any_gnt = |gnt;
  assign mem_idx = sel_addr[DEPTH_LOG2-1:0];

  // Contents survive reset; an aborted access never writes because gnt is forced low.
  always_ff @(posedge clock) begin
    if (any_gnt) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (sel_we[b]) mem_q[mem_idx][8*b +: 8] <= sel_wdata[8*b +: 8];
      end
    end
  end

  // Read-before-write: rdata captures the word as it was before this edge's write.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rdata_q  <= '0;
      rvalid_q <= '0;
    end else begin
      rvalid_q <= gnt;
      if (any_gnt) rdata_q <= mem_q[mem_idx];
    end
  end

  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;

`ifdef OWNER_MAILBOX_EN
  logic [OW-1:0]     owner_q, owner_d;
  logic [ADDR_W-1:0] mbox_off;
  logic              mbox_hit;

  always_comb begin
    owner_d  = owner_q;
    mbox_off = sel_addr - MBOX_BASE;
    mbox_hit = any_gnt && sel_we[0] && (sel_addr >= MBOX_BASE) &&
               (mbox_off < ADDR_W'(NPORTS));
    if (mbox_hit) owner_d = OW'(mbox_off);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) owner_q <= '0;
    else        owner_q <= owner_d;
  end

  always_comb begin
    mask = '0;
    for (int p = 0; p < NPORTS; p++) begin
      mask[p] = (owner_q == OW'(p));
    end
  end

  assign owner = owner_q;
`else
  logic unused_mbox;

  assign mask        = '1;
  assign owner       = '0;
  assign unused_mbox = ^{MBOX_BASE, sel_addr};
`endif

endmodule

// File: tb/tb_shared_memory_arbiter.sv
// tb/tb_shared_memory_arbiter.sv - directed self-checking bench for shared_memory_arbiter
module tb_shared_memory_arbiter;

  logic        clock;
  logic        reset;
  logic [1:0]  req;
  logic [33:0] addr;
  logic [7:0]  wr_en;
  logic [63:0] wdata;
  logic [1:0]  gnt;
  logic [31:0] rdata;
  logic [1:0]  rvalid;
  logic [0:0]  owner;

  int n_checks;
  int n_fail;

  shared_memory_arbiter #(
    .NPORTS     (2),
    .DEPTH_LOG2 (10),
    .NBYTES     (4),
    .MBOX_BASE  (17'h20)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .req    (req),
    .addr   (addr),
    .wr_en  (wr_en),
    .wdata  (wdata),
    .gnt    (gnt),
    .rdata  (rdata),
    .rvalid (rvalid),
    .owner  (owner)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic idle();
    req   = '0;
    addr  = '0;
    wr_en = '0;
    wdata = '0;
  endtask

  task automatic set_port(input int p, input logic [16:0] a, input logic [3:0] we,
                          input logic [31:0] wd);
    req[p]              = 1'b1;
    addr[p*17 +: 17]    = a;
    wr_en[p*4 +: 4]     = we;
    wdata[p*32 +: 32]   = wd;
  endtask

  task automatic do_reset();
    @(negedge clock);
    idle();
    reset = 1'b0;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle();
    req = 2'b11;
    repeat (2) @(posedge clock);
    #1;
    n_checks++;
    if (gnt !== 2'b00) begin n_fail++; $display("FAIL reset_gnt: got %b expected 00", gnt); end
    n_checks++;
    if (rvalid !== 2'b00) begin n_fail++; $display("FAIL reset_rvalid: got %b expected 00", rvalid); end
    n_checks++;
    if (rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 00000000", rdata); end
    n_checks++;
    if (owner !== 1'b0) begin n_fail++; $display("FAIL reset_owner: got %b expected 0", owner); end
    @(negedge clock);
    idle();
    reset = 1'b1;
  endtask

  task automatic test_write_read();
    @(negedge clock); idle(); set_port(0, 17'h005, 4'hF, 32'hDEADBEEF);
    #1; n_checks++;
    if (gnt !== 2'b01) begin n_fail++; $display("FAIL wr_gnt: got %b expected 01", gnt); end
    @(posedge clock); #1; n_checks++;
    if (rvalid !== 2'b01) begin n_fail++; $display("FAIL wr_rvalid: got %b expected 01", rvalid); end
    @(negedge clock); idle(); set_port(0, 17'h005, 4'h0, 32'h0);
    #1; n_checks++;
    if (gnt !== 2'b01) begin n_fail++; $display("FAIL rd_gnt_back_to_back: got %b expected 01", gnt); end
    @(posedge clock); #1; n_checks++;
    if (rvalid !== 2'b01) begin n_fail++; $display("FAIL rd_rvalid: got %b expected 01", rvalid); end
    n_checks++;
    if (rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_rdata: got %h expected deadbeef", rdata); end
    @(negedge clock); idle();
    #1; n_checks++;
    if (gnt !== 2'b00) begin n_fail++; $display("FAIL idle_gnt: got %b expected 00", gnt); end
    @(posedge clock); #1; n_checks++;
    if (rvalid !== 2'b00) begin n_fail++; $display("FAIL idle_rvalid: got %b expected 00", rvalid); end
    n_checks++;
    if (rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL idle_rdata_hold: got %h expected deadbeef", rdata); end
  endtask

  task automatic test_byte_lanes();
    @(negedge clock); idle(); set_port(1, 17'h005, 4'b0001, 32'h000000AA);
    #1; n_checks++;
    if (gnt !== 2'b10) begin n_fail++; $display("FAIL lane_gnt: got %b expected 10", gnt); end
    @(posedge clock); #1; n_checks++;
    if (rvalid !== 2'b10) begin n_fail++; $display("FAIL lane_rvalid: got %b expected 10", rvalid); end
    n_checks++;
    if (rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lane_prewrite_rdata: got %h expected deadbeef", rdata); end
    @(negedge clock); idle(); set_port(0, 17'h005, 4'h0, 32'h0);
    @(posedge clock); #1; n_checks++;
    if (rdata !== 32'hDEADBEAA) begin n_fail++; $display("FAIL lane_merge_rdata: got %h expected deadbeaa", rdata); end
    @(negedge clock); idle(); set_port(1, 17'h405, 4'h0, 32'h0);
    #1; n_checks++;
    if (gnt !== 2'b10) begin n_fail++; $display("FAIL alias_gnt: got %b expected 10", gnt); end
    @(posedge clock); #1; n_checks++;
    if (rvalid !== 2'b10) begin n_fail++; $display("FAIL alias_rvalid: got %b expected 10", rvalid); end
    n_checks++;
    if (rdata !== 32'hDEADBEAA) begin n_fail++; $display("FAIL alias_rdata: got %h expected deadbeaa", rdata); end
  endtask

  task automatic test_round_robin();
    logic [1:0] rr_exp [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clock); idle();
      set_port(0, 17'h005, 4'h0, 32'h0);
      set_port(1, 17'h005, 4'h0, 32'h0);
      #1; n_checks++;
      if (gnt !== rr_exp[i]) begin n_fail++; $display("FAIL rr_gnt[%0d]: got %b expected %b", i, gnt, rr_exp[i]); end
      @(posedge clock); #1; n_checks++;
      if (rvalid !== rr_exp[i]) begin n_fail++; $display("FAIL rr_rvalid[%0d]: got %b expected %b", i, rvalid, rr_exp[i]); end
    end
    @(negedge clock); idle(); set_port(0, 17'h005, 4'h0, 32'h0);
    @(posedge clock);
    repeat (2) begin
      @(negedge clock); idle();
    end
    @(negedge clock); idle();
    set_port(0, 17'h005, 4'h0, 32'h0);
    set_port(1, 17'h005, 4'h0, 32'h0);
    #1; n_checks++;
    if (gnt !== 2'b10) begin n_fail++; $display("FAIL rr_ptr_hold_gnt: got %b expected 10", gnt); end
    @(posedge clock);
  endtask

  task automatic test_reset_abort();
    @(negedge clock); idle(); set_port(0, 17'h007, 4'hF, 32'hCAFEF00D);
    @(negedge clock); idle(); set_port(0, 17'h005, 4'h0, 32'h0);
    @(negedge clock); idle(); set_port(0, 17'h007, 4'hF, 32'h11111111);
    #1; n_checks++;
    if (gnt !== 2'b01) begin n_fail++; $display("FAIL abort_pre_gnt: got %b expected 01", gnt); end
    n_checks++;
    if (rdata !== 32'hDEADBEAA) begin n_fail++; $display("FAIL abort_pre_rdata: got %h expected deadbeaa", rdata); end
    #1; reset = 1'b0;
    #1; n_checks++;
    if (gnt !== 2'b00) begin n_fail++; $display("FAIL abort_gnt: got %b expected 00", gnt); end
    n_checks++;
    if (rvalid !== 2'b00) begin n_fail++; $display("FAIL abort_rvalid: got %b expected 00", rvalid); end
    n_checks++;
    if (rdata !== 32'h0) begin n_fail++; $display("FAIL abort_rdata: got %h expected 00000000", rdata); end
    @(posedge clock);
    @(negedge clock); idle(); reset = 1'b1;
    @(posedge clock); #1; n_checks++;
    if (rvalid !== 2'b00) begin n_fail++; $display("FAIL abort_release_rvalid: got %b expected 00", rvalid); end
    @(negedge clock); idle(); set_port(0, 17'h007, 4'h0, 32'h0);
    @(posedge clock); #1; n_checks++;
    if (rdata !== 32'hCAFEF00D) begin n_fail++; $display("FAIL abort_mem_rdata: got %h expected cafef00d", rdata); end
  endtask

`ifdef OWNER_MAILBOX_EN
  task automatic test_mailbox();
    do_reset();
    @(negedge clock); idle(); set_port(1, 17'h005, 4'h0, 32'h0);
    #1; n_checks++;
    if (gnt !== 2'b00) begin n_fail++; $display("FAIL mbox_stall_gnt: got %b expected 00", gnt); end
    @(negedge clock); set_port(0, 17'h021, 4'b0001, 32'h1);
    #1; n_checks++;
    if (gnt !== 2'b01) begin n_fail++; $display("FAIL mbox_owner_wr_gnt: got %b expected 01", gnt); end
    @(posedge clock); #1; n_checks++;
    if (owner !== 1'b1) begin n_fail++; $display("FAIL mbox_owner1: got %b expected 1", owner); end
    @(negedge clock); idle(); set_port(1, 17'h005, 4'h0, 32'h0);
    #1; n_checks++;
    if (gnt !== 2'b10) begin n_fail++; $display("FAIL mbox_port1_gnt: got %b expected 10", gnt); end
    @(negedge clock); idle(); set_port(1, 17'h020, 4'b0001, 32'h0);
    @(posedge clock); #1; n_checks++;
    if (owner !== 1'b0) begin n_fail++; $display("FAIL mbox_owner0: got %b expected 0", owner); end
    @(negedge clock); idle(); set_port(0, 17'h022, 4'b0001, 32'h1);
    @(posedge clock); #1; n_checks++;
    if (owner !== 1'b0) begin n_fail++; $display("FAIL mbox_out_of_range: got %b expected 0", owner); end
  endtask
`else
  task automatic test_owner_fixed();
    @(negedge clock); idle(); set_port(1, 17'h021, 4'b0001, 32'h1);
    #1; n_checks++;
    if (gnt !== 2'b10) begin n_fail++; $display("FAIL owner_fixed_gnt: got %b expected 10", gnt); end
    @(posedge clock);
    @(negedge clock); idle();
    #1; n_checks++;
    if (owner !== 1'b0) begin n_fail++; $display("FAIL owner_fixed: got %b expected 0", owner); end
  endtask
`endif

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
`ifdef OWNER_MAILBOX_EN
    test_mailbox();
`else
    test_write_read();
    test_byte_lanes();
    test_round_robin();
    test_reset_abort();
    test_owner_fixed();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/shared_memory_arbiter.md
SHARED_MEMORY_ARBITER -- requirements
Module: shared_memory_arbiter

Interface
REQ-001 SHALL have parameter NPORTS, default 2: number of requesting bus masters (CPU, IOPs), range 2..8.
REQ-002 SHALL have parameter DEPTH_LOG2, default 10: memory holds 2**DEPTH_LOG2 words.
REQ-003 SHALL have parameter NBYTES, default 4: byte lanes per word; data width is 8*NBYTES.
REQ-004 SHALL have parameter MBOX_BASE, default 17'h20: word address of the first ownership mailbox.
REQ-005 SHALL have port clock, input, 1: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port req, input, NPORTS: per-port access request.
REQ-008 SHALL have port addr, input, NPORTS*17: per-port word address, bits [15:31] convention.
REQ-009 SHALL have port wr_en, input, NPORTS*NBYTES: per-port byte write enables; all zero means read.
REQ-010 SHALL have port wdata, input, NPORTS*8*NBYTES: per-port write data.
REQ-011 SHALL have port gnt, output, NPORTS: one-hot-or-zero grant, combinational in the request cycle.
REQ-012 SHALL have port rdata, output, 8*NBYTES: shared registered read data.
REQ-013 SHALL have port rvalid, output, NPORTS: one-hot-or-zero, marks the port that owns rdata this cycle.
REQ-014 SHALL have port owner, output, clog2(NPORTS): current mailbox owner.

Function
REQ-015 SHALL grant at most one port per cycle: round-robin, search starting at the port after the last granted port.
REQ-016 SHALL leave the round-robin pointer unchanged in cycles with no grant.
REQ-017 SHALL perform the granted access on the rising edge that ends the grant cycle; address is masked to DEPTH_LOG2 bits.
REQ-018 SHALL write only lanes with wr_en set; unselected lanes keep their contents.
REQ-019 SHALL load rdata with the pre-write word on every granted access (read-before-write); rvalid pulses for exactly one cycle, one cycle after grant.
REQ-020 SHALL let a lone requester be granted on consecutive cycles with no bubble.
REQ-021 SHALL require an ungranted port to hold req, addr, wr_en and wdata stable; the block does not queue.
REQ-022 SHALL keep rdata unchanged and rvalid zero in cycles following no grant.

Reset
REQ-023 SHALL, while reset is low, drive gnt=0, rvalid=0, rdata=0, pointer=0, owner=0, regardless of clock.
REQ-024 SHALL abort an access in flight when reset is asserted; no rvalid follows reset release.
REQ-025 SHALL NOT clear memory contents on reset; contents load only by bench preload.

Configuration
REQ-026 With OWNER_MAILBOX_EN defined, SHALL grant only the port equal to owner; other requests stall.
REQ-027 With OWNER_MAILBOX_EN defined, a granted write with wr_en lane 0 set to MBOX_BASE+k, k<NPORTS, SHALL set owner=k from the next cycle; the write also reaches memory.
REQ-028 With OWNER_MAILBOX_EN defined, mailbox writes with k>=NPORTS SHALL not change owner.
REQ-029 Without OWNER_MAILBOX_EN, SHALL apply pure round-robin to all ports; owner SHALL stay 0.

Structure
REQ-030 SHALL take the default parameters, the MBOX_BASE default and a clog2 helper from shared package mem_arb_pkg.
REQ-031 SHALL place grant selection and the pointer in one sub-module rr_arbiter (inputs req and mask, output gnt); memory array and mailbox logic stay in the top.

Verification
REQ-032 Port0 writes 0xDEADBEEF to 0x005 with wr_en=1111, then reads 0x005 -> rvalid[0] one cycle after grant, rdata=0xDEADBEEF.
REQ-033 Port1 writes 0x000000AA to 0x005 with wr_en=0001 over 0xDEADBEEF -> later read returns 0xDEADBEAA.
REQ-034 Ports 0 and 1 both hold req for 4 cycles, pointer at reset -> gnt sequence 01,10,01,10.
REQ-035 Read address 0x405 with DEPTH_LOG2=10 -> returns the word at 0x005.
REQ-036 OWNER_MAILBOX_EN, owner 0: port1 requests and stalls; port0 writes 0x21 with lane 0 set -> owner=1 next cycle, port1 granted; port1 writes 0x20 -> owner=0.
REQ-037 Reset asserted low while port0 is granted -> gnt, rvalid, rdata are 0 at once; memory word at the target is still readable after release.
